// File: rtl/bnn_layer_seq.sv
// ---------------------------------------------------------------------------
// bnn_layer_seq
//
// Purpose:
//   Sequencer for one fully-connected binarised neural-network layer. A frame
//   is a 16-bit input vector x delivered as two bytes (low byte first) from a
//   UART receive path. For each output neuron n the sequencer reads one
//   16-bit weight word from an external ROM, computes the XNOR-popcount of
//   x against the weights and sets result[n] when the popcount reaches
//   THRESH. The packed result byte is then offered to the UART transmit
//   path with a valid/ready handshake.
//
// Parameters:
//   N_OUT  - output neurons per frame (1..8)
//   THRESH - popcount firing threshold (0..17); THRESH=17 never fires
//
// Ports:
//   clk        in   1   clock, rising-edge active
//   rst_n      in   1   asynchronous active-low reset
//   in_data    in   8   received byte
//   in_valid   in   1   in_data valid
//   in_ready   out  1   byte accepted this cycle (LOAD_LO / LOAD_HI)
//   w_rd       out  1   weight ROM read strobe (FETCH)
//   w_addr     out  3   weight ROM address = current neuron index
//   w_data     in   16  weight word, valid the cycle after w_rd
//   out_data   out  8   result byte
//   out_valid  out  1   out_data valid (SEND)
//   out_ready  in   1   transmit path accepts out_data
//   busy       out  1   high in FETCH, CALC and SEND
//   abort      in   1   synchronous frame abort (only with the macro below)
//
// Configuration:
//   BNN_LAYER_SEQ_ABORT_EN - when defined, adds the abort port. An abort at a
//   rising edge returns the sequencer to LOAD_LO and clears n and result,
//   taking priority over any handshake in that cycle.
// ---------------------------------------------------------------------------
module bnn_layer_seq #(
   parameter int unsigned N_OUT  = 8,
   parameter int unsigned THRESH = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        w_rd,
   output logic [2:0]  w_addr,
   input  logic [15:0] w_data,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy
`ifdef BNN_LAYER_SEQ_ABORT_EN
   ,
   input  logic        abort
`endif
);

   typedef enum logic [2:0] {
      LOAD_LO = 3'd0,
      LOAD_HI = 3'd1,
      FETCH   = 3'd2,
      CALC    = 3'd3,
      SEND    = 3'd4
   } state_e;

   localparam logic [2:0] N_LAST   = 3'(N_OUT - 1);
   localparam logic [5:0] THRESH_W = 6'(THRESH);

   // Number of set bits in a 16-bit word (0..16).
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, v[i]};
      end
      return cnt;
   endfunction

   state_e      state_q, state_d;
   logic [15:0] x_q, x_d;
   logic [2:0]  n_q, n_d;
   logic [7:0]  result_q, result_d;
   logic        in_ready_q, in_ready_d;
   logic        w_rd_q, w_rd_d;
   logic        out_valid_q, out_valid_d;
   logic        busy_q, busy_d;

   logic        abort_s;
   logic [4:0]  pc_s;
   logic        fire_s;

`ifdef BNN_LAYER_SEQ_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   // XNOR-popcount of the input vector against the weight word in CALC.
   assign pc_s   = popcount16(~(x_q ^ w_data));
   assign fire_s = ({1'b0, pc_s} >= THRESH_W);

   // Next-state, datapath and next-output decode for the frame sequencer.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      n_d      = n_q;
      result_d = result_q;

      case (state_q)
         LOAD_LO: begin
            if (in_valid) begin
               x_d[7:0] = in_data;
               state_d  = LOAD_HI;
            end else begin
               state_d  = LOAD_LO;
            end
         end
         LOAD_HI: begin
            if (in_valid) begin
               x_d[15:8] = in_data;
               n_d       = 3'd0;
               result_d  = 8'd0;
               state_d   = FETCH;
            end else begin
               state_d   = LOAD_HI;
            end
         end
         FETCH: begin
            // w_data arrives in the following cycle, i.e. in CALC.
            state_d = CALC;
         end
         CALC: begin
            result_d[n_q] = fire_s;
            if (n_q == N_LAST) begin
               state_d = SEND;
            end else begin
               n_d     = n_q + 3'd1;
               state_d = FETCH;
            end
         end
         SEND: begin
            if (out_ready) begin
               state_d = LOAD_LO;
            end else begin
               state_d = SEND;
            end
         end
         default: begin
            state_d  = LOAD_LO;
            n_d      = 3'd0;
            result_d = 8'd0;
         end
      endcase

      // Abort overrides whatever the handshakes above decided.
      if (abort_s) begin
         state_d  = LOAD_LO;
         n_d      = 3'd0;
         result_d = 8'd0;
      end else begin
         state_d  = state_d;
      end

      // Outputs are decoded from the next state so they are registered
      // and line up with the state they describe.
      in_ready_d  = (state_d == LOAD_LO) || (state_d == LOAD_HI);
      w_rd_d      = (state_d == FETCH);
      out_valid_d = (state_d == SEND);
      busy_d      = (state_d == FETCH) || (state_d == CALC) || (state_d == SEND);
   end

   // Frame sequencer state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LOAD_LO;
         x_q         <= 16'd0;
         n_q         <= 3'd0;
         result_q    <= 8'd0;
         in_ready_q  <= 1'b1;
         w_rd_q      <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         n_q         <= n_d;
         result_q    <= result_d;
         in_ready_q  <= in_ready_d;
         w_rd_q      <= w_rd_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign w_rd      = w_rd_q;
   assign w_addr    = n_q;
   // Bits above N_OUT-1 are never written after the clear in LOAD_HI.
   assign out_data  = result_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule
